// File: rtl/riscoffee_mem_arbiter.sv
// Shared single-port RAM arbiter for the RISCoffee core.
// It arbitrates between instruction fetch (IF) and load/store (MA). MA has
// priority, and an anti-starvation counter forces an IF grant after
// STARVE_LIMIT consecutive MA wins. Grants and RAM commands are combinational
// in the request cycle. Responses come exactly one cycle later and are built
// from a registered response tag and the RAM read word.
module riscoffee_mem_arbiter #(
  parameter int ADDR_WIDTH   = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  IF_REQ,
  input  logic [31:0]           IF_ADDR,
  output logic                  IF_GNT,
  output logic                  IF_RVALID,
  output logic                  IF_ERR,
  output logic [31:0]           IF_RDATA,
  input  logic                  MA_REQ,
  input  logic                  MA_WE,
  input  logic [1:0]            MA_SIZE,
  input  logic                  MA_UNSIGNED,
  input  logic [31:0]           MA_ADDR,
  input  logic [31:0]           MA_WDATA,
  output logic                  MA_GNT,
  output logic                  MA_RVALID,
  output logic                  MA_ERR,
  output logic [31:0]           MA_RDATA,
  output logic                  RAM_EN,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [3:0]            RAM_WE,
  output logic [31:0]           RAM_WDATA,
  input  logic [31:0]           RAM_RDATA
);

  // The counter must be able to hold STARVE_LIMIT itself; a limit of 0 means IF always wins.
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // MA misalignment check; the reserved size 3 always counts as an error.
  function automatic logic ma_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Per-byte write enables for an aligned store.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // The store data is replicated across lanes, so the byte enables alone select the target bytes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Pick the addressed lane out of the RAM word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [CW-1:0] starve_cnt_r;
  logic          if_gnt_s;
  logic          ma_gnt_s;
  logic          if_err_s;
  logic          ma_err_s;

  logic          rsp_valid_r;
  logic          rsp_ma_r;
  logic          rsp_we_r;
  logic [1:0]    rsp_size_r;
  logic          rsp_uns_r;
  logic [1:0]    rsp_off_r;
  logic          rsp_err_r;

  // Address bits above the RAM window are ignored by design.
  logic          unused_s;
  assign unused_s = ^{IF_ADDR, MA_ADDR};

  assign if_err_s = (IF_ADDR[1:0] != 2'b00);
  assign ma_err_s = ma_misaligned(MA_SIZE, MA_ADDR[1:0]);
  assign IF_GNT   = if_gnt_s;
  assign MA_GNT   = ma_gnt_s;

  // Arbitration: MA first, except when IF has already waited through STARVE_LIMIT MA grants.
  always_comb begin
    if_gnt_s = 1'b0;
    ma_gnt_s = 1'b0;
    if (!RSTN) begin
      if_gnt_s = 1'b0;
      ma_gnt_s = 1'b0;
    end else if (MA_REQ && !(IF_REQ && (starve_cnt_r == LIMIT))) begin
      ma_gnt_s = 1'b1;
    end else if (IF_REQ) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      ma_gnt_s = 1'b0;
    end
  end

  // RAM command for the granted access; misaligned grants leave the RAM untouched.
  always_comb begin
    RAM_EN    = 1'b0;
    RAM_ADDR  = '0;
    RAM_WE    = 4'b0000;
    RAM_WDATA = 32'h0000_0000;
    if (ma_gnt_s && !ma_err_s) begin
      RAM_EN   = 1'b1;
      RAM_ADDR = MA_ADDR[ADDR_WIDTH+1:2];
      if (MA_WE) begin
        RAM_WE    = lane_mask(MA_SIZE, MA_ADDR[1:0]);
        RAM_WDATA = lane_data(MA_SIZE, MA_WDATA);
      end else begin
        RAM_WE    = 4'b0000;
        RAM_WDATA = 32'h0000_0000;
      end
    end else if (if_gnt_s && !if_err_s) begin
      RAM_EN   = 1'b1;
      RAM_ADDR = IF_ADDR[ADDR_WIDTH+1:2];
    end else begin
      RAM_EN = 1'b0;
    end
  end

  // Starvation counter: counts MA grants while IF waits and resets once IF is served or idle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      starve_cnt_r <= '0;
    end else if (!IF_REQ || if_gnt_s) begin
      starve_cnt_r <= '0;
    end else if (ma_gnt_s && (starve_cnt_r != LIMIT)) begin
      starve_cnt_r <= starve_cnt_r + CW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Response tag captured at grant; it is valid for exactly the following cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rsp_valid_r <= 1'b0;
      rsp_ma_r    <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_size_r  <= 2'd0;
      rsp_uns_r   <= 1'b0;
      rsp_off_r   <= 2'd0;
      rsp_err_r   <= 1'b0;
    end else if (ma_gnt_s) begin
      rsp_valid_r <= 1'b1;
      rsp_ma_r    <= 1'b1;
      rsp_we_r    <= MA_WE;
      rsp_size_r  <= MA_SIZE;
      rsp_uns_r   <= MA_UNSIGNED;
      rsp_off_r   <= MA_ADDR[1:0];
      rsp_err_r   <= ma_err_s;
    end else if (if_gnt_s) begin
      rsp_valid_r <= 1'b1;
      rsp_ma_r    <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_size_r  <= SZ_WORD;
      rsp_uns_r   <= 1'b0;
      rsp_off_r   <= IF_ADDR[1:0];
      rsp_err_r   <= if_err_s;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_ma_r    <= rsp_ma_r;
      rsp_we_r    <= rsp_we_r;
      rsp_size_r  <= rsp_size_r;
      rsp_uns_r   <= rsp_uns_r;
      rsp_off_r   <= rsp_off_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  // Response outputs: data and error are forced to zero outside the owner's valid cycle.
  always_comb begin
    IF_RVALID = 1'b0;
    IF_ERR    = 1'b0;
    IF_RDATA  = 32'h0000_0000;
    MA_RVALID = 1'b0;
    MA_ERR    = 1'b0;
    MA_RDATA  = 32'h0000_0000;
    if (rsp_valid_r && rsp_ma_r) begin
      MA_RVALID = 1'b1;
      MA_ERR    = rsp_err_r;
      if (!rsp_err_r && !rsp_we_r) begin
        MA_RDATA = load_extend(RAM_RDATA, rsp_size_r, rsp_uns_r, rsp_off_r);
      end else begin
        MA_RDATA = 32'h0000_0000;
      end
    end else if (rsp_valid_r) begin
      IF_RVALID = 1'b1;
      IF_ERR    = rsp_err_r;
      if (!rsp_err_r) begin
        IF_RDATA = RAM_RDATA;
      end else begin
        IF_RDATA = 32'h0000_0000;
      end
    end else begin
      IF_RVALID = 1'b0;
      MA_RVALID = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscoffee_mem_arbiter.sv
// Self-checking bench for riscoffee_mem_arbiter: directed scenarios plus
// randomized traffic, compared against a byte-level behavioural model.
module tb_riscoffee_mem_arbiter;

  localparam int AW  = 10;
  localparam int LIM = 4;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          IF_REQ, IF_GNT, IF_RVALID, IF_ERR;
  logic [31:0]   IF_ADDR, IF_RDATA;
  logic          MA_REQ, MA_WE, MA_UNSIGNED, MA_GNT, MA_RVALID, MA_ERR;
  logic [1:0]    MA_SIZE;
  logic [31:0]   MA_ADDR, MA_WDATA, MA_RDATA;
  logic          RAM_EN;
  logic [AW-1:0] RAM_ADDR;
  logic [3:0]    RAM_WE;
  logic [31:0]   RAM_WDATA;
  logic [31:0]   RAM_RDATA = 32'h0;

  logic [31:0]   ram_arr [0:(1<<AW)-1] = '{default: 32'h0};
  logic [7:0]    ref_bytes [0:4095] = '{default: 8'h0};

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          starve = 0;
  bit          rsp_pend = 1'b0, rsp_is_ma = 1'b0, rsp_err = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  bit          m_if_g, m_ma_g;

  // Snapshots of DUT outputs from the last checked cycle
  logic          snap_if_gnt, snap_ma_gnt, snap_ram_en;
  logic [3:0]    snap_ram_we;
  logic [31:0]   snap_wdata;
  logic [AW-1:0] snap_ram_addr;
  logic          snap_if_rvalid, snap_ma_rvalid, snap_ma_err;
  logic [31:0]   snap_if_rdata, snap_ma_rdata;

  riscoffee_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
    .IF_RVALID(IF_RVALID), .IF_ERR(IF_ERR), .IF_RDATA(IF_RDATA),
    .MA_REQ(MA_REQ), .MA_WE(MA_WE), .MA_SIZE(MA_SIZE), .MA_UNSIGNED(MA_UNSIGNED),
    .MA_ADDR(MA_ADDR), .MA_WDATA(MA_WDATA), .MA_GNT(MA_GNT),
    .MA_RVALID(MA_RVALID), .MA_ERR(MA_ERR), .MA_RDATA(MA_RDATA),
    .RAM_EN(RAM_EN), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE),
    .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
  );

  always #5 CLK = ~CLK;

  // RAM with one-cycle read latency and per-byte write enables
  always @(posedge CLK) begin
    if (RAM_EN) begin
      RAM_RDATA <= ram_arr[RAM_ADDR];
      for (int k = 0; k < 4; k++)
        if (RAM_WE[k]) ram_arr[RAM_ADDR][8*k +: 8] <= RAM_WDATA[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Little-endian read from the byte model, extended as a RISC-V load would be.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    logic [11:0] a;
    logic [31:0] v;
    a = addr[11:0];
    if (size == 2'd0) begin
      v = {24'h0, ref_bytes[a]};
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = {16'h0, ref_bytes[a + 12'd1], ref_bytes[a]};
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = {ref_bytes[a + 12'd3], ref_bytes[a + 12'd2], ref_bytes[a + 12'd1], ref_bytes[a]};
    end
    return v;
  endfunction

  // One clock cycle: check DUT at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic          e_if, e_ma, ie, me, e_en;
    logic [3:0]    e_we;
    logic [31:0]   e_wd;
    logic [AW-1:0] e_addr;
    logic [11:0]   a;
    @(negedge CLK);
    e_ma = RSTN && MA_REQ && !(IF_REQ && starve == LIM);
    e_if = RSTN && IF_REQ && !e_ma;
    ie   = (IF_ADDR[1:0] != 2'b00);
    me   = (MA_SIZE == 2'd3) || (MA_SIZE == 2'd1 && MA_ADDR[0]) ||
           (MA_SIZE == 2'd2 && MA_ADDR[1:0] != 2'b00);
    e_en   = (e_if && !ie) || (e_ma && !me);
    e_addr = e_ma ? MA_ADDR[AW+1:2] : IF_ADDR[AW+1:2];
    e_we = 4'b0000;
    e_wd = 32'h0;
    if (e_ma && !me && MA_WE) begin
      case (MA_SIZE)
        2'd0: begin e_we = 4'b0001 << MA_ADDR[1:0]; e_wd = {4{MA_WDATA[7:0]}}; end
        2'd1: begin e_we = MA_ADDR[1] ? 4'b1100 : 4'b0011; e_wd = {2{MA_WDATA[15:0]}}; end
        default: begin e_we = 4'b1111; e_wd = MA_WDATA; end
      endcase
    end
    chk("if_gnt", 32'(IF_GNT), 32'(e_if));
    chk("ma_gnt", 32'(MA_GNT), 32'(e_ma));
    chk("ram_en", 32'(RAM_EN), 32'(e_en));
    chk("ram_we", 32'(RAM_WE), 32'(e_we));
    if (e_en) chk("ram_addr", 32'(RAM_ADDR), 32'(e_addr));
    if (e_we != 4'b0000) chk("ram_wdata", RAM_WDATA, e_wd);
    chk("if_rvalid", 32'(IF_RVALID), 32'(rsp_pend && !rsp_is_ma));
    chk("if_err", 32'(IF_ERR), 32'(rsp_pend && !rsp_is_ma && rsp_err));
    chk("if_rdata", IF_RDATA, (rsp_pend && !rsp_is_ma) ? rsp_data : 32'h0);
    chk("ma_rvalid", 32'(MA_RVALID), 32'(rsp_pend && rsp_is_ma));
    chk("ma_err", 32'(MA_ERR), 32'(rsp_pend && rsp_is_ma && rsp_err));
    chk("ma_rdata", MA_RDATA, (rsp_pend && rsp_is_ma) ? rsp_data : 32'h0);
    snap_if_gnt = IF_GNT;  snap_ma_gnt = MA_GNT;  snap_ram_en = RAM_EN;
    snap_ram_we = RAM_WE;  snap_wdata = RAM_WDATA; snap_ram_addr = RAM_ADDR;
    snap_if_rvalid = IF_RVALID; snap_if_rdata = IF_RDATA;
    snap_ma_rvalid = MA_RVALID; snap_ma_err = MA_ERR; snap_ma_rdata = MA_RDATA;
    @(posedge CLK);
    m_if_g = e_if;
    m_ma_g = e_ma;
    if (!RSTN) begin
      rsp_pend = 1'b0;
      starve   = 0;
    end else begin
      rsp_pend  = e_if || e_ma;
      rsp_is_ma = e_ma;
      rsp_err   = e_ma ? me : ie;
      rsp_data  = 32'h0;
      if (e_ma && !me && !MA_WE) rsp_data = ref_load(MA_ADDR, MA_SIZE, MA_UNSIGNED);
      if (e_if && !ie) rsp_data = ref_load(IF_ADDR, 2'd2, 1'b0);
      if (e_ma && !me && MA_WE) begin
        a = MA_ADDR[11:0];
        for (int k = 0; k < (1 << MA_SIZE); k++) ref_bytes[a + 12'(k)] = MA_WDATA[8*k +: 8];
      end
      if (!IF_REQ || e_if) starve = 0;
      else if (e_ma && starve < LIM) starve++;
    end
    #1;
  endtask

  task automatic ma_set(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    MA_REQ = 1'b1; MA_WE = we; MA_SIZE = size; MA_UNSIGNED = uns;
    MA_ADDR = addr; MA_WDATA = wdata;
  endtask

  initial begin
    RSTN = 1'b0;
    IF_REQ = 1'b1; IF_ADDR = 32'h0;
    ma_set(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    // Reset: requests present but nothing granted, no RAM activity
    cycle();
    cycle();
    chk("rst_ram_en", 32'(snap_ram_en), 32'h0);
    chk("rst_ma_gnt", 32'(snap_ma_gnt), 32'h0);
    RSTN = 1'b1; IF_REQ = 1'b0; MA_REQ = 1'b0;
    cycle();

    // Fetch of a stored word
    ma_set(1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFE_F00D);
    cycle(); MA_REQ = 1'b0;
    IF_REQ = 1'b1; IF_ADDR = 32'h100;
    cycle(); IF_REQ = 1'b0;
    chk("fetch_gnt", 32'(snap_if_gnt), 32'h1);
    chk("fetch_ram_addr", 32'(snap_ram_addr), 32'h40);
    cycle();
    chk("fetch_rvalid", 32'(snap_if_rvalid), 32'h1);
    chk("fetch_rdata", snap_if_rdata, 32'hCAFE_F00D);

    // Byte store then signed / unsigned byte loads
    ma_set(1'b1, 2'd0, 1'b0, 32'h203, 32'h1234_56AB);
    cycle();
    chk("sb_we", 32'(snap_ram_we), 32'h8);
    chk("sb_wdata", snap_wdata, 32'hABAB_ABAB);
    ma_set(1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
    cycle();
    chk("sb_rsp_valid", 32'(snap_ma_rvalid), 32'h1);
    chk("sb_rsp_data", snap_ma_rdata, 32'h0);
    ma_set(1'b0, 2'd0, 1'b1, 32'h203, 32'h0);
    cycle(); MA_REQ = 1'b0;
    chk("lb_signed", snap_ma_rdata, 32'hFFFF_FFAB);
    cycle();
    chk("lbu", snap_ma_rdata, 32'h0000_00AB);

    // Half loads from the upper half of 0x80017F00
    ma_set(1'b1, 2'd2, 1'b0, 32'h200, 32'h8001_7F00);
    cycle();
    ma_set(1'b0, 2'd1, 1'b0, 32'h202, 32'h0);
    cycle();
    ma_set(1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
    cycle(); MA_REQ = 1'b0;
    chk("lh_signed", snap_ma_rdata, 32'hFFFF_8001);
    cycle();
    chk("lhu", snap_ma_rdata, 32'h0000_8001);

    // Misaligned word load: granted, no RAM access, error response
    ma_set(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    cycle(); MA_REQ = 1'b0;
    chk("mis_gnt", 32'(snap_ma_gnt), 32'h1);
    chk("mis_ram_en", 32'(snap_ram_en), 32'h0);
    cycle();
    chk("mis_rvalid", 32'(snap_ma_rvalid), 32'h1);
    chk("mis_err", 32'(snap_ma_err), 32'h1);
    chk("mis_rdata", snap_ma_rdata, 32'h0);

    // Continuous contention: MA,MA,MA,MA,IF repeating
    IF_REQ = 1'b1; IF_ADDR = 32'h0;
    ma_set(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("starve_pattern", 32'(snap_ma_gnt), 32'((i % 5) != 4));
    end
    IF_REQ = 1'b0; MA_REQ = 1'b0;
    cycle();

    // Randomized traffic with held requests and occasional withdrawal
    for (int n = 0; n < 400; n++) begin
      if (!IF_REQ) begin
        if ($urandom_range(0, 2) == 0) begin
          IF_REQ  = 1'b1;
          IF_ADDR = ($urandom & 32'hFFFF_F03C) |
                    (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        end
      end else if ($urandom_range(0, 9) == 0) begin
        IF_REQ = 1'b0;
      end
      if (!MA_REQ) begin
        if ($urandom_range(0, 1) == 0)
          ma_set(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                 $urandom & 32'hFFFF_F03F, $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        MA_REQ = 1'b0;
      end
      cycle();
      if (m_if_g) IF_REQ = 1'b0;
      if (m_ma_g) MA_REQ = 1'b0;
    end
    IF_REQ = 1'b0; MA_REQ = 1'b0;
    cycle();

    // Reset between grant and response discards the fetch
    IF_REQ = 1'b1; IF_ADDR = 32'h100;
    @(negedge CLK);
    chk("rstfetch_gnt", 32'(IF_GNT), 32'h1);
    #2 RSTN = 1'b0;
    rsp_pend = 1'b0;
    starve   = 0;
    #1 chk("rstfetch_rvalid_async", 32'(IF_RVALID), 32'h0);
    @(posedge CLK);
    #1 IF_REQ = 1'b0;
    cycle();
    chk("rstfetch_rvalid_in_rst", 32'(snap_if_rvalid), 32'h0);
    RSTN = 1'b1;
    cycle();
    chk("rstfetch_rvalid_after", 32'(snap_if_rvalid), 32'h0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
